mem_unaligned: RTL and testbench
================================

// Module: mem_unaligned
// PURPOSE
//  Word-organised, byte-addressable data memory with a valid/ready request and response interface.
//  Supports BYTE/HALF/WORD accesses at any byte address: a word-crossing access runs as two word beats.
//  Intended as the next-generation data memory behind the load/store unit. Uses mem_pkg::mem_width_t.
// PARAMETERS
//  AddrWidth        12  byte-address width; Depth = 2**(AddrWidth-2) words
//  AllowMisaligned  1   1: word-crossing accesses are split into two beats; 0: they return an error
//  InitFile         ""  $readmemh word image; empty = contents undefined at start-up
// PORTS
//  clk              in   1          single clock, all state updates on posedge
//  reset            in   1          synchronous, active-high
//  req_valid        in   1          request present
//  req_ready        out  1          request accepted when req_valid && req_ready
//  req_write        in   1          1 = store, 0 = load
//  req_width        in   mem_width_t BYTE / HALF / WORD
//  req_sign_extend  in   1          loads only: sign- (1) or zero-extend (0) BYTE/HALF
//  req_address      in   AddrWidth  byte address
//  req_data         in   32         store data, right-aligned (low bytes used)
//  rsp_valid        out  1          response present
//  rsp_ready        in   1          response consumed when rsp_valid && rsp_ready
//  rsp_data         out  32         load result, extended; 0 for stores and errors
//  rsp_error        out  1          access rejected; memory untouched
// BEHAVIOUR
//  - One clock, clk. reset is synchronous and active-high. Reset affects the FSM and outputs only, not the array.
//  - Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0.
//  - Little-endian: byte at address a lives in word a>>2, lane a[1:0]. size = 1/2/4 bytes.
//  - crossing = (a[1:0] + size) > 4. Words are w0 = a>>2 and w1 = w0+1.
//  - Error when: crossing && !AllowMisaligned; or crossing && w0 == Depth-1 (no wrap-around).
//    On error: no write occurs; IDLE->RESP; rsp_error=1; rsp_data=0.
//  - The array has a synchronous read (1 cycle) and per-byte write enables. No read-modify-write.
//  - FSM states:
//    IDLE:   req_ready=1. On accept:
//            - non-crossing: issue w0 read/write -> RESP.
//            - crossing: issue w0 beat, latch request -> SECOND.
//    SECOND: req_ready=0. Issue w1 beat (remaining bytes, lanes starting at 0) -> RESP.
//    RESP:   req_ready=0, rsp_valid=1. rsp_data/rsp_error are registered and held stable. On rsp_ready -> IDLE.
//  - Latency, accept cycle N to rsp_valid: non-crossing or error = N+1; crossing = N+2.
//  - Throughput is at most one request per 2 cycles. A new request is accepted only in IDLE.
//  - Load assembly: the w0 upper lanes form the low bytes, and the w1 low lanes form the high bytes.
//    Then extend from bit 8*size-1 per req_sign_extend. WORD ignores req_sign_extend.
//  - Store: byte k of req_data goes to byte address a+k, for k < size. Other lanes are unchanged.
//  - rsp_ready held low: stay in RESP and hold all outputs. rsp_ready may be high before rsp_valid rises.
//  - Reset in SECOND: the w1 beat is dropped, and the w0 bytes already written remain. Reset in RESP: the response is discarded.
//  - Request inputs are sampled only on the accept cycle and may change afterwards.
// TESTING
//  1. Reset -> req_ready=1 and rsp_valid=0 next cycle.
//     Then WORD store 0x1234_5678 @0, then WORD load @0 -> 0x1234_5678, err=0, rsp_valid at N+1.
//  2. WORD store 0 @4, then HALF store 0xBEEF @3 (crossing).
//     -> rsp_valid at N+2; WORD load @0 -> 0xEF34_5678; WORD load @4 -> 0x0000_00BE.
//  3. HALF load @3, sign_extend=1 -> 0xFFFF_BEEF at N+2; sign_extend=0 -> 0x0000_BEEF.
//     BYTE load @2, sign_extend=1 -> 0x0000_0034.
//  4. AllowMisaligned=0 instance: WORD store @1 -> rsp_error=1 at N+1.
//     Then WORD load @0 is unchanged. WORD store at last byte address minus 1 (default instance) -> rsp_error=1, no write.
//  5. Hold rsp_ready=0 for 3 cycles after a load -> rsp_valid/rsp_data stable, req_ready=0.
//     Raise rsp_ready -> IDLE next cycle, next request accepted.
//  6. Assert reset in SECOND of a crossing WORD store 0xAABB_CCDD @2 -> next cycle IDLE, rsp_valid=0.
//     WORD load @0 -> 0xCCDD_xxxx; word @4 is unchanged.

Source files
------------

// File: rtl/mem_unaligned.sv
// Word-organised, byte-addressable data memory with valid/ready request and response.
// Word-crossing BYTE/HALF/WORD accesses run as two word beats (or are rejected).
package mem_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_width_t;
endpackage

module mem_unaligned
  import mem_pkg::*;
#(
  parameter int unsigned AddrWidth       = 12,
  parameter bit          AllowMisaligned = 1'b1,
  parameter string       InitFile        = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  mem_width_t           req_width,
  input  logic                 req_sign_extend,
  input  logic [AddrWidth-1:0] req_address,
  input  logic [31:0]          req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_error
);
  localparam int unsigned WW    = AddrWidth - 2;
  localparam int unsigned Depth = 2 ** WW;

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] off_q, off_d;
  mem_width_t width_q, width_d;
  logic       sext_q, sext_d;
  logic       write_q, write_d;
  logic       err_q, err_d;
  logic       cross_q, cross_d;
  logic [WW-1:0] w1_addr_q, w1_addr_d;
  logic [31:0]   w1_data_q, w1_data_d;
  logic [3:0]    w1_be_q, w1_be_d;
  logic [31:0]   lo_q, lo_d;

  logic [31:0]   mem_q [Depth];
  logic [31:0]   rd_q;
  logic [WW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_re;

  logic [1:0]    off;
  logic [WW-1:0] w0;
  logic [2:0]    size;
  logic [3:0]    mask;
  logic          crossing;
  logic [63:0]   wide_data;
  logic [7:0]    wide_be;

  always_comb begin
    off = req_address[1:0];
    w0  = req_address[AddrWidth-1:2];
    case (req_width)
      BYTE:    begin size = 3'd1; mask = 4'b0001; end
      HALF:    begin size = 3'd2; mask = 4'b0011; end
      default: begin size = 3'd4; mask = 4'b1111; end
    endcase
    crossing  = ({1'b0, off} + size) > 3'd4;
    // Shift across a two-word window: the upper half is the w1 beat.
    wide_data = {32'b0, req_data} << {off, 3'b000};
    wide_be   = {4'b0, mask} << off;
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    width_d   = width_q;
    sext_d    = sext_q;
    write_d   = write_q;
    err_d     = err_q;
    cross_d   = cross_q;
    w1_addr_d = w1_addr_q;
    w1_data_d = w1_data_q;
    w1_be_d   = w1_be_q;
    lo_d      = lo_q;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d     = off;
          width_d   = req_width;
          sext_d    = req_sign_extend;
          write_d   = req_write;
          cross_d   = crossing;
          err_d     = crossing && (!AllowMisaligned || w0 == '1);
          w1_addr_d = w0 + WW'(1);
          w1_data_d = wide_data[63:32];
          w1_be_d   = wide_be[7:4];
          if (err_d) begin
            state_d = RESP;
          end else begin
            mem_addr = w0;
            if (req_write) begin
              mem_be    = wide_be[3:0];
              mem_wdata = wide_data[31:0];
            end else begin
              mem_re = 1'b1;
            end
            state_d = crossing ? SECOND : RESP;
          end
        end
      end
      SECOND: begin
        mem_addr = w1_addr_q;
        if (write_q) begin
          mem_be    = w1_be_q;
          mem_wdata = w1_data_q;
        end else begin
          mem_re = 1'b1;
        end
        lo_d    = rd_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset edge must not commit the pending beat.
    if (reset) begin
      mem_be = '0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= reset ? IDLE : state_d;
    off_q     <= off_d;
    width_q   <= width_d;
    sext_q    <= sext_d;
    write_q   <= write_d;
    err_q     <= err_d;
    cross_q   <= cross_d;
    w1_addr_q <= w1_addr_d;
    w1_data_q <= w1_data_d;
    w1_be_q   <= w1_be_d;
    lo_q      <= lo_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_be[i]) mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    if (mem_re) rd_q <= mem_q[mem_addr];
  end

  logic [63:0] pair;
  logic [31:0] raw;
  logic [31:0] ext;

  // Response is built from registers only (rd_q, lo_q, latched request), so it holds in RESP.
  always_comb begin
    pair = {rd_q, (cross_q ? lo_q : rd_q)} >> {off_q, 3'b000};
    raw  = pair[31:0];
    case (width_q)
      BYTE:    ext = {{24{sext_q & raw[7]}}, raw[7:0]};
      HALF:    ext = {{16{sext_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_error = (state_q == RESP) && err_q;
    rsp_data  = (state_q == RESP && !write_q && !err_q) ? ext : '0;
  end
endmodule

// File: tb/tb_mem_unaligned.sv
// Directed self-checking bench for mem_unaligned: instance 0 default, instance 1 rejects misalignment.
module tb_mem_unaligned;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv[2], rrdy[2], rw[2], sx[2], rspv[2], rspr[2], rerr[2];
  mem_width_t  wd[2];
  logic [11:0] ad[2];
  logic [31:0] dt[2], rd[2];

  int pass_cnt = 0;
  int total    = 0;

  mem_unaligned #(.AddrWidth(12), .AllowMisaligned(1'b1)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rrdy[0]), .req_write(rw[0]), .req_width(wd[0]),
    .req_sign_extend(sx[0]), .req_address(ad[0]), .req_data(dt[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rspr[0]), .rsp_data(rd[0]), .rsp_error(rerr[0])
  );

  mem_unaligned #(.AddrWidth(12), .AllowMisaligned(1'b0)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rrdy[1]), .req_write(rw[1]), .req_width(wd[1]),
    .req_sign_extend(sx[1]), .req_address(ad[1]), .req_data(dt[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rspr[1]), .rsp_data(rd[1]), .rsp_error(rerr[1])
  );

  // Issues one request, returns the response and the accept-to-rsp_valid latency (8 = timeout).
  task automatic do_req(input int s, input logic w, input mem_width_t width, input logic sext,
                        input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] data, output logic err, output int lat);
    int waitc = 0;
    while (!rrdy[s] && waitc < 10) begin
      @(posedge clk); #1; waitc++;
    end
    rv[s] = 1'b1; rw[s] = w; wd[s] = width; sx[s] = sext; ad[s] = a; dt[s] = d;
    @(posedge clk); #1;
    rv[s] = 1'b0; ad[s] = 12'h5A5; dt[s] = 32'hDEAD_0000; sx[s] = ~sext;
    lat = 1;
    while (!rspv[s] && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    data = rd[s];
    err  = rerr[s];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (rrdy[0] !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", rrdy[0]); else pass_cnt++;
    total++; if (rspv[0] !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rspv[0]); else pass_cnt++;
    total++; if (rd[0] !== 32'h0) $display("FAIL reset_rsp_data: got %h expected 0", rd[0]); else pass_cnt++;
    total++; if (rerr[0] !== 1'b0) $display("FAIL reset_rsp_error: got %b expected 0", rerr[0]); else pass_cnt++;
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int lat;
    do_req(0, 1'b1, WORD, 1'b0, 12'h000, 32'h1234_5678, d, e, lat);
    total++; if (lat !== 1) $display("FAIL word_store_lat: got %0d expected 1", lat); else pass_cnt++;
    total++; if (d !== 32'h0 || e !== 1'b0) $display("FAIL word_store_rsp: got %h/%b expected 0/0", d, e); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h000, 32'h0, d, e, lat);
    total++; if (d !== 32'h1234_5678) $display("FAIL word_load: got %h expected 12345678", d); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL word_load_err: got %b expected 0", e); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL word_load_lat: got %0d expected 1", lat); else pass_cnt++;
  endtask

  task automatic test_crossing_store();
    logic [31:0] d; logic e; int lat;
    do_req(0, 1'b1, WORD, 1'b0, 12'h004, 32'h0, d, e, lat);
    do_req(0, 1'b1, HALF, 1'b0, 12'h003, 32'h0000_BEEF, d, e, lat);
    total++; if (lat !== 2) $display("FAIL cross_store_lat: got %0d expected 2", lat); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h000, 32'h0, d, e, lat);
    total++; if (d !== 32'hEF34_5678) $display("FAIL cross_word0: got %h expected ef345678", d); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h004, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000_00BE) $display("FAIL cross_word1: got %h expected 000000be", d); else pass_cnt++;
  endtask

  task automatic test_load_extend();
    logic [31:0] d; logic e; int lat;
    do_req(0, 1'b0, HALF, 1'b1, 12'h003, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFF_BEEF) $display("FAIL half_sext: got %h expected ffffbeef", d); else pass_cnt++;
    total++; if (lat !== 2) $display("FAIL half_cross_lat: got %0d expected 2", lat); else pass_cnt++;
    do_req(0, 1'b0, HALF, 1'b0, 12'h003, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000_BEEF) $display("FAIL half_zext: got %h expected 0000beef", d); else pass_cnt++;
    do_req(0, 1'b0, BYTE, 1'b1, 12'h002, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000_0034) $display("FAIL byte_sext_pos: got %h expected 00000034", d); else pass_cnt++;
    do_req(0, 1'b0, BYTE, 1'b1, 12'h003, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFF_FFEF) $display("FAIL byte_sext_neg: got %h expected ffffffef", d); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    do_req(1, 1'b1, WORD, 1'b0, 12'h000, 32'h1122_3344, d, e, lat);
    do_req(1, 1'b1, WORD, 1'b0, 12'h001, 32'h9999_9999, d, e, lat);
    total++; if (e !== 1'b1) $display("FAIL misalign_err: got %b expected 1", e); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL misalign_err_lat: got %0d expected 1", lat); else pass_cnt++;
    total++; if (d !== 32'h0) $display("FAIL misalign_err_data: got %h expected 0", d); else pass_cnt++;
    do_req(1, 1'b0, WORD, 1'b0, 12'h000, 32'h0, d, e, lat);
    total++; if (d !== 32'h1122_3344) $display("FAIL misalign_nowrite: got %h expected 11223344", d); else pass_cnt++;
    do_req(0, 1'b1, WORD, 1'b0, 12'hFFC, 32'h5566_7788, d, e, lat);
    do_req(0, 1'b1, WORD, 1'b0, 12'hFFE, 32'h9999_9999, d, e, lat);
    total++; if (e !== 1'b1) $display("FAIL top_wrap_err: got %b expected 1", e); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'hFFC, 32'h0, d, e, lat);
    total++; if (d !== 32'h5566_7788) $display("FAIL top_wrap_nowrite: got %h expected 55667788", d); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL top_load_err: got %b expected 0", e); else pass_cnt++;
  endtask

  task automatic test_rsp_hold();
    logic [31:0] d; logic e; int lat;
    rspr[0] = 1'b0;
    rv[0] = 1'b1; rw[0] = 1'b0; wd[0] = WORD; sx[0] = 1'b0; ad[0] = 12'h000;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    total++; if (rspv[0] !== 1'b1) $display("FAIL hold_first_valid: got %b expected 1", rspv[0]); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rspv[0] !== 1'b1 || rd[0] !== 32'hEF34_5678 || rrdy[0] !== 1'b0)
        $display("FAIL hold_stable[%0d]: got v=%b d=%h rdy=%b expected 1/ef345678/0", i, rspv[0], rd[0], rrdy[0]);
      else pass_cnt++;
    end
    rspr[0] = 1'b1;
    @(posedge clk); #1;
    total++; if (rspv[0] !== 1'b0 || rrdy[0] !== 1'b1)
      $display("FAIL hold_release: got v=%b rdy=%b expected 0/1", rspv[0], rrdy[0]); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h004, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000_00BE || lat !== 1)
      $display("FAIL hold_next_req: got %h lat %0d expected 000000be lat 1", d, lat); else pass_cnt++;
  endtask

  task automatic test_reset_second();
    logic [31:0] d; logic e; int lat;
    rv[0] = 1'b1; rw[0] = 1'b1; wd[0] = WORD; sx[0] = 1'b0; ad[0] = 12'h002; dt[0] = 32'hAABB_CCDD;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    total++; if (rrdy[0] !== 1'b0 || rspv[0] !== 1'b0)
      $display("FAIL second_state: got rdy=%b v=%b expected 0/0", rrdy[0], rspv[0]); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (rspv[0] !== 1'b0 || rrdy[0] !== 1'b1)
      $display("FAIL reset_second: got v=%b rdy=%b expected 0/1", rspv[0], rrdy[0]); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h000, 32'h0, d, e, lat);
    total++; if (d !== 32'hCCDD_5678) $display("FAIL reset_w0_kept: got %h expected ccdd5678", d); else pass_cnt++;
    do_req(0, 1'b0, WORD, 1'b0, 12'h004, 32'h0, d, e, lat);
    total++; if (d !== 32'h0000_00BE) $display("FAIL reset_w1_dropped: got %h expected 000000be", d); else pass_cnt++;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; rw[s] = 1'b0; wd[s] = WORD; sx[s] = 1'b0;
      ad[s] = '0; dt[s] = '0; rspr[s] = 1'b1;
    end
    reset = 1'b1;
    test_reset();
    test_word();
    test_crossing_store();
    test_load_extend();
    test_errors();
    test_rsp_hold();
    test_reset_second();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
